// File: rtl/ddr_wr_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr_wr_serializer_pkg
// Brief    : Shared types and helpers for the DDR write-data serializer.
// Revision : 1.0 - initial release
// ============================================================================
package ddr_wr_serializer_pkg;

    typedef enum logic [1:0] {
        BL2  = 2'd0,
        BL4  = 2'd1,
        BL8  = 2'd2,
        BL16 = 2'd3
    } burst_len_t;

    typedef enum logic [1:0] {
        WS_IDLE  = 2'd0,
        WS_PRE   = 2'd1,
        WS_BURST = 2'd2,
        WS_POST  = 2'd3
    } wr_ser_state_t;

    function automatic logic [4:0] bl_beats(input burst_len_t bl);
        logic [4:0] beats;
        case (bl)
            BL2:     beats = 5'd2;
            BL4:     beats = 5'd4;
            BL8:     beats = 5'd8;
            default: beats = 5'd16;
        endcase
        return beats;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_wr_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : ddr_wr_serializer_if
// Brief    : Write-word handshake plus PHY-facing DQ/DM/DQS bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface ddr_wr_serializer_if #(
    parameter int DQ_W   = 8,
    parameter int BL_MAX = 8
);
    import ddr_wr_serializer_pkg::*;

    localparam int DATA_W = DQ_W * BL_MAX;
    localparam int LANES  = DQ_W / 8;

    logic                wr_valid;
    logic                wr_ready;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W/8-1:0] wr_strb;
    burst_len_t          wr_bl;

    logic [DQ_W-1:0]     dq_rise;
    logic [DQ_W-1:0]     dq_fall;
    logic [LANES-1:0]    dm_rise;
    logic [LANES-1:0]    dm_fall;
    logic                dq_oe;
    logic                dqs_rise;
    logic                dqs_fall;
    logic                dqs_oe;
    logic                bl_err;

    modport master (
        output wr_valid, wr_data, wr_strb, wr_bl,
        input  wr_ready, dq_rise, dq_fall, dm_rise, dm_fall, dq_oe,
               dqs_rise, dqs_fall, dqs_oe, bl_err
    );

    modport slave (
        input  wr_valid, wr_data, wr_strb, wr_bl,
        output wr_ready, dq_rise, dq_fall, dm_rise, dm_fall, dq_oe,
               dqs_rise, dqs_fall, dqs_oe, bl_err
    );

endinterface
`default_nettype wire

// File: rtl/ddr_beat_shifter.sv
`default_nettype none
// ============================================================================
// Module   : ddr_beat_shifter
// Brief    : Data/strobe shift register exposing a two-beat output window.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_beat_shifter #(
    parameter int DQ_W   = 8,
    parameter int BL_MAX = 8
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        load,
    input  logic                        shift,
    input  logic [DQ_W*BL_MAX-1:0]      load_data,
    input  logic [DQ_W*BL_MAX/8-1:0]    load_strb,
    output logic [DQ_W-1:0]             beat0,
    output logic [DQ_W-1:0]             beat1,
    output logic [DQ_W/8-1:0]           strb0,
    output logic [DQ_W/8-1:0]           strb1
);
    localparam int DATA_W = DQ_W * BL_MAX;
    localparam int STRB_W = DATA_W / 8;
    localparam int LANES  = DQ_W / 8;
    localparam int STEP_D = 2 * DQ_W;
    localparam int STEP_S = 2 * LANES;

    logic [DATA_W-1:0] r_data;
    logic [STRB_W-1:0] r_strb;
    logic [DATA_W-1:0] w_data_shifted;
    logic [STRB_W-1:0] w_strb_shifted;

    // A two-beat register holds exactly one beat pair, so there is nothing to shift in.
    generate
        if (BL_MAX > 2) begin : g_shift
            assign w_data_shifted = {{STEP_D{1'b0}}, r_data[DATA_W-1:STEP_D]};
            assign w_strb_shifted = {{STEP_S{1'b0}}, r_strb[STRB_W-1:STEP_S]};
        end else begin : g_no_shift
            assign w_data_shifted = '0;
            assign w_strb_shifted = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_data <= '0;
            r_strb <= '0;
        end else if (load) begin
            r_data <= load_data;
            r_strb <= load_strb;
        end else if (shift) begin
            r_data <= w_data_shifted;
            r_strb <= w_strb_shifted;
        end
    end

    assign beat0 = r_data[DQ_W-1:0];
    assign beat1 = r_data[STEP_D-1:DQ_W];
    assign strb0 = r_strb[LANES-1:0];
    assign strb1 = r_strb[STEP_S-1:LANES];

endmodule
`default_nettype wire

// File: rtl/ddr_wr_serializer.sv
`default_nettype none
// ============================================================================
// Module   : ddr_wr_serializer
// Brief    : Serializes write words into DDR rise/fall beat pairs with DQS framing.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_wr_serializer #(
    parameter int DQ_W   = 8,
    parameter int BL_MAX = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    ddr_wr_serializer_if.slave   bus
);
    import ddr_wr_serializer_pkg::*;

    localparam int LANES   = DQ_W / 8;
    localparam int CYC_MAX = BL_MAX / 2;
    localparam int CNT_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam logic [4:0] BEATS_MAX = 5'(BL_MAX);

    wr_ser_state_t     r_state;
    wr_ser_state_t     w_state_nxt;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [CNT_W-1:0]  w_beat_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_load;
    logic [4:0]        w_req_beats;
    logic [4:0]        w_beats;
    logic              w_last;
    logic              w_accept;
    logic              w_shift;
    logic [DQ_W-1:0]   w_beat0;
    logic [DQ_W-1:0]   w_beat1;
    logic [LANES-1:0]  w_strb0;
    logic [LANES-1:0]  w_strb1;

    assign w_req_beats = bl_beats(bus.wr_bl);
    assign w_beats     = (w_req_beats > BEATS_MAX) ? BEATS_MAX : w_req_beats;
    assign w_cnt_load  = CNT_W'((w_beats >> 1) - 5'd1);

    assign w_last       = (r_beat_cnt == '0);
    assign bus.wr_ready = (r_state == WS_IDLE) || (r_state == WS_POST) ||
                          ((r_state == WS_BURST) && w_last);
    assign w_accept     = bus.wr_valid && bus.wr_ready;
    assign bus.bl_err   = w_accept && (w_req_beats > BEATS_MAX);

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        unique case (r_state)
            WS_IDLE: begin
                if (w_accept) begin
                    w_state_nxt    = WS_PRE;
                    w_beat_cnt_nxt = w_cnt_load;
                end
            end
            WS_PRE: begin
                w_state_nxt = WS_BURST;
            end
            WS_BURST: begin
                if (!w_last) begin
                    w_beat_cnt_nxt = r_beat_cnt - CNT_W'(1);
                end else if (w_accept) begin
                    // Gapless follow-on burst: DQS keeps toggling, no pre/postamble.
                    w_beat_cnt_nxt = w_cnt_load;
                end else begin
                    w_state_nxt = WS_POST;
                end
            end
            WS_POST: begin
                if (w_accept) begin
                    w_state_nxt    = WS_PRE;
                    w_beat_cnt_nxt = w_cnt_load;
                end else begin
                    w_state_nxt = WS_IDLE;
                end
            end
            default: begin
                w_state_nxt = WS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= WS_IDLE;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    assign w_shift = (r_state == WS_BURST);

    ddr_beat_shifter #(
        .DQ_W   (DQ_W),
        .BL_MAX (BL_MAX)
    ) u_shifter (
        .clk       (clk),
        .n_rst     (n_rst),
        .load      (w_accept),
        .shift     (w_shift),
        .load_data (bus.wr_data),
        .load_strb (bus.wr_strb),
        .beat0     (w_beat0),
        .beat1     (w_beat1),
        .strb0     (w_strb0),
        .strb1     (w_strb1)
    );

    assign bus.dq_oe    = (r_state == WS_BURST);
    assign bus.dqs_oe   = (r_state != WS_IDLE);
    assign bus.dqs_rise = (r_state == WS_BURST);
    assign bus.dqs_fall = 1'b0;

    assign bus.dq_rise  = bus.dq_oe ? w_beat0  : '0;
    assign bus.dq_fall  = bus.dq_oe ? w_beat1  : '0;
    assign bus.dm_rise  = bus.dq_oe ? ~w_strb0 : '0;
    assign bus.dm_fall  = bus.dq_oe ? ~w_strb1 : '0;

endmodule
`default_nettype wire

// File: doc/ddr_wr_serializer.md
Name: ddr_wr_serializer

Overview:
- Parametrised DDR write-data serializer; successor to the fixed 8-bit/64-bit write burst path.
- Accepts one write word per handshake and emits it as rise/fall beat pairs toward the PHY output register (ODDR muxes on clk). Drives DQ/DM/DQS and their output enables.
- Adds variable burst length, byte-lane write mask, explicit DQS preamble/postamble, gapless back-to-back bursts and a burst-length error flag.

Parameters:
- DQ_W, 8, DQ pins per beat; multiple of 8.
- BL_MAX, 8, max beats per burst; power of two, 2..16.
- DATA_W, DQ_W*BL_MAX, write word width (derived, not overridable).
- LANES, DQ_W/8, byte lanes per beat (derived).

Ports:
- clk  in  1  clock
- n_rst  in  1  async active-low reset
- wr_valid  in  1  write word valid
- wr_ready  out  1  block can accept word this cycle
- wr_data  in  DATA_W  burst data; beat k = wr_data[k*DQ_W +: DQ_W], beat 0 first
- wr_strb  in  DATA_W/8  byte enables, 1 = write; beat k lanes = wr_strb[k*LANES +: LANES]
- wr_bl  in  2  burst_len_t: BL2/BL4/BL8/BL16
- dq_rise  out  DQ_W  beat driven during clk high phase
- dq_fall  out  DQ_W  beat driven during clk low phase
- dm_rise  out  LANES  data mask for rise beat, 1 = masked
- dm_fall  out  LANES  data mask for fall beat
- dq_oe  out  1  DQ/DM output enable
- dqs_rise  out  1  DQS level, high phase
- dqs_fall  out  1  DQS level, low phase
- dqs_oe  out  1  DQS output enable
- bl_err  out  1  one-cycle pulse, requested BL exceeded BL_MAX

Behaviour:
- Reset (async, immediate, including mid-burst): state IDLE; all outputs 0 except wr_ready=1; shift register, beat counter and held burst length cleared.
- Handshake: word accepted on a clk edge with wr_valid && wr_ready. wr_ready is combinational from state: 1 in IDLE, 1 in POSTAMBLE, 1 in BURST only when beat_cnt == last; otherwise 0.
- Beats per burst = 2/4/8/16 for BL2/BL4/BL8/BL16; cycles per burst = beats/2.
- If requested beats exceed BL_MAX: clamp to BL_MAX and pulse bl_err in the accept cycle.
- Accept latches wr_data/wr_strb into a DATA_W shift register and loads beat_cnt = cycles-1.
- States:
  - IDLE: all OEs 0. Accept goes to PREAMBLE.
  - PREAMBLE (1 cycle): dqs_oe=1, dqs_rise=dqs_fall=0, dq_oe=0. Always goes to BURST.
  - BURST: dq_oe=1, dqs_oe=1, dqs_rise=1, dqs_fall=0. dq_rise = beat 2i, dq_fall = beat 2i+1; dm_* = ~strb of the same beats. Shift by 2*DQ_W per cycle; beat_cnt decrements.
  - On the last BURST cycle: accept goes to BURST (gapless; new word loaded, no pre/postamble). No accept goes to POSTAMBLE.
  - POSTAMBLE (1 cycle): dqs_oe=1, dqs_*=0, dq_oe=0. Accept goes to PREAMBLE. No accept goes to IDLE.
- Latency: accept at edge N gives PREAMBLE in cycle N+1 and first beat pair in cycle N+2. Back-to-back: next word's first beat pair immediately follows the previous last pair.
- All outputs are registered or decoded from registered state only; no combinational path from wr_* to outputs except wr_ready→(none) and bl_err.
- When dq_oe=0, dq_*/dm_* are driven 0 (never X/Z).

Decomposition:
- type_pkg additions:
  - burst_len_t enum {BL2, BL4, BL8, BL16}
  - wr_ser_state_t {WS_IDLE, WS_PRE, WS_BURST, WS_POST}
  - function bl_beats(burst_len_t)
- Sub-module ddr_beat_shifter: DATA_W data plus strobe shift register with load/shift and a 2-beat output window. FSM and counter stay in the top.

Test Plan:
- Single BL8, DQ_W=8, data 64'h8877665544332211, strb all 1 → cycle N+1 preamble; N+2..N+5 rise/fall = 11/22, 33/44, 55/66, 77/88; dm=0; postamble at N+6; IDLE at N+7.
- Back-to-back BL4 then BL4 (second valid held high) → 4 contiguous BURST cycles, dqs_rise=1 throughout, no preamble/postamble between bursts, wr_ready=1 only on cycles 2 and 4.
- Masked BL2, strb=8'b0000_0010 → dm_rise=1, dm_fall=0, dq_fall=data[15:8].
- BL16 with BL_MAX=8 → bl_err pulses once, burst lasts 4 cycles with beats 0..7.
- Accept in POSTAMBLE → next cycle PREAMBLE, dqs_oe stays 1 continuously.
- n_rst asserted mid-BL8 in cycle 2 → all OEs 0 immediately, wr_ready=1; a following BL2 completes normally.
